// File: rtl/channel_frame_serializer.sv
// Drains one 120-bit channel FIFO into 8-bit AXI-Stream Ethernet frames.
// Build option: define SERIALIZER_TRAILER_EN to append a 16-bit XOR trailer.
module channel_frame_serializer #(
    parameter int          DATA_W    = 120,
    parameter int          CNT_W     = 10,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [47:0]       d_mac_add,
    input  logic [47:0]       s_mac_add,
    input  logic [7:0]        channel_id,
    input  logic [11:0]       counter_th,
    input  logic [15:0]       idle_counter_number_th,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read,
    output logic [7:0]        tx_axis_fifo_tdata,
    output logic              tx_axis_fifo_tvalid,
    input  logic              tx_axis_fifo_tready,
    output logic              tx_axis_fifo_tlast,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int HDR_W = 144;

    typedef enum logic [2:0] {
        IDLE, HEADER, LOAD, CAPT, PAYLOAD, TRAILER, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [11:0]         rem_q, rem_d;
    logic [7:0]          seq_q, seq_d;
    logic [15:0]         fc_q, fc_d;
    logic [15:0]         idle_q, idle_d;
`ifdef SERIALIZER_TRAILER_EN
    logic [15:0]         chk_q, chk_d;
    logic                odd_q, odd_d;
`endif

    logic [11:0] th_eff, cnt12, n_min, n_sel;
    logic        start, acc, hdr_last, pay_last;

    assign th_eff   = (counter_th == 12'd0) ? 12'd1 : counter_th;
    assign cnt12    = 12'(fifo_count);
    assign n_min    = (cnt12 < th_eff) ? cnt12 : th_eff;
    assign n_sel    = (n_min == 12'd0 && !fifo_empty) ? 12'd1 : n_min;
    assign start    = (cnt12 >= th_eff) ||
                      (idle_counter_number_th != 16'd0 &&
                       idle_q >= idle_counter_number_th && !fifo_empty);
    assign hdr_last = (cnt_q == 5'd17);
    assign pay_last = (cnt_q == 5'(BYTES - 1));

    assign tx_axis_fifo_tvalid = (state_q == HEADER) || (state_q == PAYLOAD) ||
                                 (state_q == TRAILER);
    assign acc         = tx_axis_fifo_tvalid & tx_axis_fifo_tready;
    assign busy        = (state_q != IDLE);
    assign frame_count = fc_q;

    always_comb begin
        tx_axis_fifo_tdata = 8'h00;
        tx_axis_fifo_tlast = 1'b0;
        case (state_q)
            HEADER:  tx_axis_fifo_tdata = hdr_q[HDR_W-1 -: 8];
            PAYLOAD: begin
                tx_axis_fifo_tdata = word_q[DATA_W-1 -: 8];
`ifndef SERIALIZER_TRAILER_EN
                tx_axis_fifo_tlast = pay_last && (rem_q == 12'd0);
`endif
            end
`ifdef SERIALIZER_TRAILER_EN
            TRAILER: begin
                tx_axis_fifo_tdata = cnt_q[0] ? chk_q[7:0] : chk_q[15:8];
                tx_axis_fifo_tlast = cnt_q[0];
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        seq_d     = seq_q;
        fc_d      = fc_q;
        fifo_read = 1'b0;
`ifdef SERIALIZER_TRAILER_EN
        chk_d     = chk_q;
        odd_d     = odd_q;
`endif
        idle_d = idle_q;
        if (fifo_empty || state_q != IDLE)
            idle_d = 16'd0;
        else if (idle_q != 16'hFFFF)
            idle_d = idle_q + 16'd1;

        case (state_q)
            IDLE: if (start) begin
                hdr_d   = {d_mac_add, s_mac_add, ETHERTYPE, channel_id,
                           seq_q, 4'h0, n_sel};
                rem_d   = n_sel;
                cnt_d   = 5'd0;
                state_d = HEADER;
`ifdef SERIALIZER_TRAILER_EN
                chk_d   = 16'h0000;
                odd_d   = 1'b0;
`endif
            end
            HEADER: if (acc) begin
                hdr_d = hdr_q << 8;
                cnt_d = cnt_q + 5'd1;
                if (hdr_last) begin
                    cnt_d   = 5'd0;
                    state_d = LOAD;
                end
            end
            LOAD: if (!fifo_empty) begin
                fifo_read = 1'b1;
                rem_d     = rem_q - 12'd1;
                state_d   = CAPT;
            end
            // read data is valid the cycle after the strobe
            CAPT: begin
                word_d  = fifo_data;
                state_d = PAYLOAD;
            end
            PAYLOAD: if (acc) begin
                word_d = word_q << 8;
                cnt_d  = cnt_q + 5'd1;
                if (pay_last) begin
                    cnt_d = 5'd0;
                    if (rem_q != 12'd0)
                        state_d = LOAD;
                    else
`ifdef SERIALIZER_TRAILER_EN
                        state_d = TRAILER;
`else
                        state_d = DONE;
`endif
                end
            end
`ifdef SERIALIZER_TRAILER_EN
            TRAILER: if (acc) begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q[0]) begin
                    cnt_d   = 5'd0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                seq_d   = seq_q + 8'd1;
                fc_d    = fc_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SERIALIZER_TRAILER_EN
        // even byte positions fold into the high half, odd into the low half
        if (acc && state_q != TRAILER) begin
            chk_d = chk_q ^ (odd_q ? {8'h00, tx_axis_fifo_tdata}
                                   : {tx_axis_fifo_tdata, 8'h00});
            odd_d = ~odd_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            word_q  <= '0;
            cnt_q   <= 5'd0;
            rem_q   <= 12'd0;
            seq_q   <= 8'd0;
            fc_q    <= 16'd0;
            idle_q  <= 16'd0;
`ifdef SERIALIZER_TRAILER_EN
            chk_q   <= 16'h0000;
            odd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            fc_q    <= fc_d;
            idle_q  <= idle_d;
`ifdef SERIALIZER_TRAILER_EN
            chk_q   <= chk_d;
            odd_q   <= odd_d;
`endif
        end
    end

endmodule

// File: tb/tb_channel_frame_serializer.sv
// Bench for channel_frame_serializer: FIFO model, frame-level byte model
// and per-byte scoreboard compare.
module tb_channel_frame_serializer;

    localparam logic [47:0] DMAC = 48'hA1B2C3D4E5F6;
    localparam logic [47:0] SMAC = 48'h102030405060;
    localparam logic [7:0]  CHID = 8'h5A;
`ifdef SERIALIZER_TRAILER_EN
    localparam int TRL = 2;
`else
    localparam int TRL = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [11:0]  counter_th = 12'd4;
    logic [15:0]  idle_th = 16'd0;
    logic         fifo_empty = 1'b1;
    logic [9:0]   fifo_count = 10'd0;
    logic [119:0] fifo_data = '0;
    logic         fifo_read;
    logic [7:0]   tdata;
    logic         tvalid;
    logic         tready = 1'b1;
    logic         tlast;
    logic [15:0]  frame_count;
    logic         busy;

    always #5 clk = ~clk;

    channel_frame_serializer dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .d_mac_add              (DMAC),
        .s_mac_add              (SMAC),
        .channel_id             (CHID),
        .counter_th             (counter_th),
        .idle_counter_number_th (idle_th),
        .fifo_empty             (fifo_empty),
        .fifo_count             (fifo_count),
        .fifo_data              (fifo_data),
        .fifo_read              (fifo_read),
        .tx_axis_fifo_tdata     (tdata),
        .tx_axis_fifo_tvalid    (tvalid),
        .tx_axis_fifo_tready    (tready),
        .tx_axis_fifo_tlast     (tlast),
        .frame_count            (frame_count),
        .busy                   (busy)
    );

    typedef struct {
        logic [7:0] b;
        logic       l;
    } eb_t;

    int n_chk = 0;
    int n_fail = 0;
    eb_t exq[$];
    logic [119:0] fifo_q[$];
    logic [119:0] push_q[$];
    logic [119:0] mdl_words[$];
    logic [7:0] mdl_seq = 8'd0;
    logic [7:0] cap [0:16383];
    logic [7:0] seqlog [0:1023];
    int ncap = 0;
    int nfr = 0;
    int nrd = 0;
    int nstall = 0;
    int pos = 0;
    logic rd_seen;
    logic bp = 1'b0;
    int ph = 0;
    logic prv_stall = 1'b0;
    logic [7:0] prv_d;
    logic prv_l;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [119:0] mkw(input int k);
        logic [119:0] w;
        w = '0;
        for (int j = 0; j < 15; j++)
            w[119-8*j -: 8] = 8'(k * 16 + j);
        return w;
    endfunction

    task automatic push_w(input logic [119:0] w);
        push_q.push_back(w);
        mdl_words.push_back(w);
    endtask

    // Whole-frame model: header, payload words, optional XOR trailer
    task automatic expect_frame(input int n);
        logic [7:0]   fb[$];
        logic [119:0] w;
        logic [15:0]  ck;
        for (int i = 0; i < 6; i++) fb.push_back(DMAC[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(SMAC[47-8*i -: 8]);
        fb.push_back(8'h88);
        fb.push_back(8'hB5);
        fb.push_back(CHID);
        fb.push_back(mdl_seq);
        fb.push_back(8'(n >> 8));
        fb.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            w = mdl_words.pop_front();
            for (int j = 0; j < 15; j++) fb.push_back(w[119-8*j -: 8]);
        end
        ck = 16'h0000;
        for (int i = 0; i < fb.size(); i++)
            ck ^= (i % 2 == 0) ? {fb[i], 8'h00} : {8'h00, fb[i]};
        if (TRL == 2) begin
            fb.push_back(ck[15:8]);
            fb.push_back(ck[7:0]);
        end
        for (int i = 0; i < fb.size(); i++)
            exq.push_back('{b: fb[i], l: (i == fb.size() - 1)});
        mdl_seq = mdl_seq + 8'd1;
    endtask

    task automatic wait_fc(input logic [15:0] target, input int budget);
        int i;
        i = 0;
        while (frame_count != target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("frame_count", frame_count, target);
    endtask

    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_seen <= 1'b0;
        else          rd_seen <= fifo_read;

    // Standard (non-FWFT) FIFO: data appears the cycle after the strobe
    always @(negedge clk) begin
        if (!reset_n) begin
            fifo_q.delete();
            push_q.delete();
        end else begin
            if (rd_seen) begin
                nrd++;
                if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            end
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        end
        fifo_count = 10'(fifo_q.size());
        fifo_empty = (fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        if (bp) begin
            ph = (ph == 2) ? 0 : ph + 1;
            tready = (ph == 0);
        end else begin
            tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        eb_t e;
        if (!reset_n) begin
            pos = 0;
            prv_stall = 1'b0;
        end else begin
            if (prv_stall) begin
                chk("hold_tvalid", tvalid, 1);
                chk("hold_tdata", tdata, prv_d);
                chk("hold_tlast", tlast, prv_l);
            end
            prv_stall = tvalid && !tready;
            prv_d = tdata;
            prv_l = tlast;
            if (prv_stall) nstall++;
            if (tvalid && tready) begin
                if (ncap < 16384) cap[ncap] = tdata;
                ncap++;
                if (pos == 15 && nfr < 1024) seqlog[nfr] = tdata;
                if (exq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", tdata);
                end else begin
                    e = exq.pop_front();
                    chk("byte", tdata, e.b);
                    chk("tlast", tlast, e.l);
                end
                if (tlast) begin
                    pos = 0;
                    nfr++;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin
        int base, rd0, cyc, fr0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        reset_n = 1'b1;

        // threshold-started frame of four words
        @(posedge clk); #2;
        counter_th = 12'd4;
        base = ncap;
        rd0 = nrd;
        for (int k = 1; k <= 4; k++) push_w(mkw(k));
        expect_frame(4);
        wait_fc(16'd1, 600);
        chk("c1_len", ncap - base, 78 + TRL);
        chk("c1_reads", nrd - rd0, 4);
        chk("c1_ethertype_hi", cap[base+12], 8'h88);
        chk("c1_seq", cap[base+15], 8'h00);
        chk("c1_n_hi", cap[base+16], 8'h00);
        chk("c1_n_lo", cap[base+17], 8'h04);
        chk("c1_first_payload", cap[base+18], 8'h10);

        // idle-timeout flush of two words
        @(posedge clk); #2;
        counter_th = 12'd8;
        idle_th = 16'd100;
        base = ncap;
        push_w(mkw(5));
        push_w(mkw(6));
        expect_frame(2);
        @(negedge clk);
        cyc = 0;
        while (!busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_start_cycles", cyc, 101);
        wait_fc(16'd2, 600);
        chk("idle_len", ncap - base, 48 + TRL);
        chk("idle_n_lo", cap[base+17], 8'h02);
        chk("idle_seq", cap[base+15], 8'h01);
        idle_th = 16'd0;

        // backpressure: ready one cycle in three
        @(posedge clk); #2;
        bp = 1'b1;
        counter_th = 12'd4;
        base = ncap;
        for (int k = 7; k <= 10; k++) push_w(mkw(k));
        expect_frame(4);
        wait_fc(16'd3, 2000);
        chk("bp_len", ncap - base, 78 + TRL);
        chk("bp_stalls_seen", nstall > 0, 1);
        @(posedge clk); #2;
        bp = 1'b0;

        // reset in the middle of the payload
        @(posedge clk); #2;
        base = ncap;
        for (int k = 11; k <= 14; k++) push_w(mkw(k));
        expect_frame(4);
        cyc = 0;
        while (ncap < base + 25 && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_payload_reached", ncap >= base + 25, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("abort_tvalid", tvalid, 0);
        chk("abort_busy", busy, 0);
        exq.delete();
        mdl_words.delete();
        mdl_seq = 8'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("abort_frame_count", frame_count, 0);
        reset_n = 1'b1;

        // 257 back-to-back single-word frames: seq wraps
        @(posedge clk); #2;
        counter_th = 12'd1;
        fr0 = nfr;
        for (int k = 0; k < 257; k++) push_w(mkw(k + 20));
        for (int k = 0; k < 257; k++) expect_frame(1);
        wait_fc(16'd257, 30000);
        chk("seq_frame1", seqlog[fr0], 8'h00);
        chk("seq_frame256", seqlog[fr0+255], 8'hFF);
        chk("seq_frame257", seqlog[fr0+256], 8'h00);

`ifdef SERIALIZER_TRAILER_EN
        @(posedge clk); #2;
        base = ncap;
        push_w(120'h0102030405060708090A0B0C0D0E0F);
        expect_frame(1);
        wait_fc(16'd258, 600);
        chk("trailer_len", ncap - base, 35);
`endif

        repeat (5) @(posedge clk);
        #2;
        chk("exp_drained", exq.size(), 0);
        chk("final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
